// File: rtl/mul_arb_pkg.sv
// Shared definitions for the two-requester multiplier arbiter.
package mul_arb_pkg;

    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned REQ_IDX_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mul_arb_mul.sv
// Combinational unsigned multiplier returning the low W bits of a*b.
module mul #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] prod_c
);

    assign prod_c = a * b;

endmodule

// File: rtl/mul_arb.sv
// Round-robin arbiter in front of a shared multiplier: IDLE accepts one pair,
// CALC registers the product, RESP holds the result until the consumer takes it.
module mul_arb
    import mul_arb_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_rs1,
    input  logic [N-1:0] req0_rs2,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_rs1,
    input  logic [N-1:0] req1_rs2,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [N-1:0] rsp_rd,
    input  logic         rsp_ready
);

    arb_state_e           state_q, state_d;
    logic [REQ_IDX_W-1:0] last_q, last_d;
    logic [REQ_IDX_W-1:0] id_q, id_d;
    logic [N-1:0]         op1_q, op1_d;
    logic [N-1:0]         op2_q, op2_d;
    logic [N-1:0]         rd_q, rd_d;
    logic                 vld_q, vld_d;

    logic [NUM_REQ-1:0]   req_valid;
    logic [REQ_IDX_W-1:0] winner;
    logic                 accept;
    logic [N-1:0]         prod;

    mul #(.W(N)) u_mul (
        .a      (op1_q),
        .b      (op2_q),
        .prod_c (prod)
    );

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        req_valid  = {req1_valid, req0_valid};
        winner     = '0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req_valid == 2'b11) begin
            winner = ~last_q;
        end else begin
            winner = REQ_IDX_W'(req_valid[1]);
        end
        if (state_q == ST_IDLE) begin
            req0_ready = req_valid[0] && (winner == 1'b0);
            req1_ready = req_valid[1] && (winner == 1'b1);
        end
        accept = req0_ready || req1_ready;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rd_d    = rd_q;
        vld_d   = vld_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op1_d   = winner[0] ? req1_rs1 : req0_rs1;
                    op2_d   = winner[0] ? req1_rs2 : req0_rs2;
                    id_d    = winner;
                    last_d  = winner;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                rd_d    = prod;
                vld_d   = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                vld_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            id_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rd_q    <= rd_d;
            vld_q   <= vld_d;
        end
    end

    assign rsp_valid = vld_q;
    assign rsp_id    = id_q[0];
    assign rsp_rd    = rd_q;

endmodule

// File: tb/tb_mul_arb.sv
// Directed bench for mul_arb: arbitration order, latency, overflow, backpressure, reset abort.
module tb_mul_arb;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_rs1, req0_rs2;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_rs1, req1_rs2;
    logic        rsp_valid, rsp_id;
    logic [15:0] rsp_rd;
    logic        rsp_ready;

    int unsigned n_checks;
    int unsigned n_errors;

    mul_arb #(.N(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_rs1   (req0_rs1),
        .req0_rs2   (req0_rs2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_rs1   (req1_rs1),
        .req1_rs2   (req1_rs2),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_rd     (rsp_rd),
        .rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transaction from IDLE: drive, check grant, CALC, RESP, then handshake.
    task automatic run_one(input logic v0, input logic v1,
                           input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] a1, input logic [15:0] b1,
                           input logic exp_id, input logic [15:0] exp_rd,
                           input logic keep, input string tag);
        req0_valid = v0; req0_rs1 = a0; req0_rs2 = b0;
        req1_valid = v1; req1_rs1 = a1; req1_rs2 = b1;
        rsp_ready  = 1'b1;
        #2;
        chk({tag, "_rdy0"}, 32'(req0_ready), 32'(!exp_id));
        chk({tag, "_rdy1"}, 32'(req1_ready), 32'(exp_id));
        @(posedge clk); #1;
        if (!keep) begin
            if (exp_id) req1_valid = 1'b0;
            else        req0_valid = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_calc_vld"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_calc_rdy"}, 32'({req1_ready, req0_ready}), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"},  32'(rsp_id),    32'(exp_id));
        chk({tag, "_rd"},  32'(rsp_rd),    32'(exp_rd));
        @(posedge clk); #1;
        chk({tag, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_rs1 = '0; req0_rs2 = '0;
        req1_valid = 1'b0; req1_rs1 = '0; req1_rs2 = '0;
        rsp_ready = 1'b1;
        #3;
        chk("rst_vld", 32'(rsp_valid), 32'd0);
        chk("rst_id",  32'(rsp_id),    32'd0);
        chk("rst_rd",  32'(rsp_rd),    32'd0);
        chk("rst_rdy", 32'({req1_ready, req0_ready}), 32'd0);

        // Release and request in the same cycle: first edge must accept.
        @(negedge clk);
        rst_n = 1'b1;
        run_one(1'b1, 1'b0, 16'd3, 16'd5, 16'd0, 16'd0, 1'b0, 16'd15, 1'b0, "single");

        // Fresh tie after reset goes to requester 0 because last grant reset to 1.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_one(1'b1, 1'b1, 16'd7, 16'd6, 16'd2, 16'd9, 1'b0, 16'd42, 1'b0, "tie_a");
        run_one(1'b0, 1'b1, 16'd7, 16'd6, 16'd2, 16'd9, 1'b1, 16'd18, 1'b0, "tie_b");

        for (int i = 0; i < 4; i++) begin
            run_one(1'b1, 1'b1, 16'd7, 16'd6, 16'd2, 16'd9, i[0], i[0] ? 16'd18 : 16'd42,
                    1'b1, $sformatf("b2b%0d", i));
        end

        run_one(1'b0, 1'b1, 16'd0, 16'd0, 16'hFFFF, 16'h0002, 1'b1, 16'hFFFE, 1'b0, "ovf_a");
        run_one(1'b0, 1'b1, 16'd0, 16'd0, 16'h0100, 16'h0100, 1'b1, 16'h0000, 1'b0, "ovf_b");

        // Backpressure: RESP held while a second requester waits.
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_rs1 = 16'd4; req0_rs2 = 16'd4;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_rs1 = 16'd5; req1_rs2 = 16'd5;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_vld%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_rd%0d", i),  32'(rsp_rd),    32'd16);
            chk($sformatf("bp_id%0d", i),  32'(rsp_id),    32'd0);
            chk($sformatf("bp_rdy%0d", i), 32'({req1_ready, req0_ready}), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_rdy", 32'({req1_ready, req0_ready}), 32'd0);
        chk("bp_hs_vld", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        run_one(1'b0, 1'b1, 16'd0, 16'd0, 16'd5, 16'd5, 1'b1, 16'd25, 1'b0, "bp_next");

        // Reset during CALC drops the operation.
        req0_valid = 1'b1; req0_rs1 = 16'd9; req0_rs2 = 16'd9;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rd",  32'(rsp_rd),    32'd0);
        chk("mid_rst_id",  32'(rsp_id),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("no_stale%0d", i), 32'(rsp_valid), 32'd0);
        end
        run_one(1'b1, 1'b0, 16'd11, 16'd13, 16'd0, 16'd0, 1'b0, 16'd143, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
